// File: rtl/address_decoder_if.sv
// CPU data-port bundle between the core and the address decoder.
// master: CPU side (drives requests); slave: decoder side (drives enables/select/fault).
interface address_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 16
);

  // CPU request
  logic                  wen;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] addr;

  // Decoder response
  logic                  wen1;
  logic                  wen2;
  logic [1:0]            out_sel;
  logic                  fault;

  modport master (
    output wen,
    output ren,
    output addr,
    input  wen1,
    input  wen2,
    input  out_sel,
    input  fault
  );

  modport slave (
    input  wen,
    input  ren,
    input  addr,
    output wen1,
    output wen2,
    output out_sel,
    output fault
  );

endinterface

// File: rtl/address_decoder.sv
// Data-side memory-map decoder for the rv32i system.
// Write enables are combinational (memory writes at the next edge); the read-data mux
// select and the unmapped-access fault are registered to line up with the one-cycle
// read latency of the synchronous memories.
module address_decoder #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] R1_BASE    = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] R1_SIZE    = 16'h2000,
  parameter logic [ADDR_WIDTH-1:0] R2_BASE    = 16'h2000,
  parameter logic [ADDR_WIDTH-1:0] R2_SIZE    = 16'h1000
) (
  input  logic               clk,
  input  logic               rst,     // synchronous, active-low
  address_decoder_if.slave   cpu_bus
);

  // Read-data mux select encoding; 2'b11 is never produced.
  typedef enum logic [1:0] {
    SelNone = 2'b00,
    SelR1   = 2'b01,
    SelR2   = 2'b10
  } sel_e;

  // One extra bit so that base + size == 2**ADDR_WIDTH does not wrap.
  localparam int unsigned         ExtW   = ADDR_WIDTH + 1;
  localparam logic [ExtW-1:0]     R1Base = {1'b0, R1_BASE};
  localparam logic [ExtW-1:0]     R1Size = {1'b0, R1_SIZE};
  localparam logic [ExtW-1:0]     R2Base = {1'b0, R2_BASE};
  localparam logic [ExtW-1:0]     R2Size = {1'b0, R2_SIZE};

  logic [ExtW-1:0] addr_ext;
  logic [ExtW-1:0] off1;
  logic [ExtW-1:0] off2;
  logic            in_r1;
  logic            in_r2;
  logic            hit1;
  logic            hit2;
  logic            unmapped;

  sel_e            out_sel_d, out_sel_q;
  logic            fault_d, fault_q;

  // Region hit detection. base <= addr < base + size is evaluated as
  // (addr - base) < size at ExtW bits: an address below base wraps to at least
  // 2**ADDR_WIDTH + 1, which always exceeds any legal size, so one compare suffices.
  always_comb begin
    addr_ext = {1'b0, cpu_bus.addr};
    off1     = addr_ext - R1Base;
    off2     = addr_ext - R2Base;
    in_r1    = (off1 < R1Size);
    in_r2    = (off2 < R2Size);
    hit1     = in_r1;
    hit2     = in_r2 & ~in_r1;  // region 1 wins on overlap
    unmapped = ~hit1 & ~hit2;
  end

  // Combinational write enables, gated by wen first so addr is irrelevant when idle,
  // and held low for as long as reset is asserted.
  always_comb begin
    cpu_bus.wen1 = cpu_bus.wen & hit1 & rst;
    cpu_bus.wen2 = cpu_bus.wen & hit2 & rst;
  end

  // Next read select and fault for the data returned in the following cycle.
  always_comb begin
    out_sel_d = SelNone;
    fault_d   = 1'b0;
    if (cpu_bus.ren && hit1) begin
      out_sel_d = SelR1;
    end else if (cpu_bus.ren && hit2) begin
      out_sel_d = SelR2;
    end
    if ((cpu_bus.wen || cpu_bus.ren) && unmapped) begin
      fault_d = 1'b1;
    end
  end

  // Select/fault registers; reset discards any pending read or fault.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_sel_q <= SelNone;
      fault_q   <= 1'b0;
    end else begin
      out_sel_q <= out_sel_d;
      fault_q   <= fault_d;
    end
  end

  // Registered outputs onto the bus.
  always_comb begin
    cpu_bus.out_sel = out_sel_q;
    cpu_bus.fault   = fault_q;
  end

`ifndef SYNTHESIS
  // The two write enables are mutually exclusive by construction.
  wen_onehot_a: assert property (@(posedge clk) !(cpu_bus.wen1 && cpu_bus.wen2));
  // The unused select code must never appear.
  sel_legal_a: assert property (@(posedge clk) rst |-> cpu_bus.out_sel != 2'b11);
`endif

endmodule

// File: tb/tb_address_decoder.sv
// Scoreboard bench for address_decoder: the stimulus process pushes expected responses
// computed from the memory map with plain integer arithmetic; a monitor pops them.
module tb_address_decoder;

  localparam int AW  = 16;
  localparam int R1B = 'h0000;
  localparam int R1S = 'h2000;
  localparam int R2B = 'h2000;
  localparam int R2S = 'h1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  address_decoder_if #(.ADDR_WIDTH(AW)) bus ();

  address_decoder #(
    .ADDR_WIDTH (AW),
    .R1_BASE    (16'h0000),
    .R1_SIZE    (16'h2000),
    .R2_BASE    (16'h2000),
    .R2_SIZE    (16'h1000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_bus (bus.slave)
  );

  typedef struct {
    bit    wen1;
    bit    wen2;
    string tag;
  } comb_t;

  typedef struct {
    int    sel;
    bit    fault;
    string tag;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic bit in_region(int a, int base, int size);
    return (a >= base) && (a < base + size);
  endfunction

  task automatic chk(string name, string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s]: got %0d expected %0d at %0t", name, tag, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the reference response.
  task automatic drive(bit r, bit w, bit rd, int a, string tag);
    comb_t c;
    reg_t  q;
    bit    h1;
    bit    h2;
    @(negedge clk);
    rst      = r;
    bus.wen  = w;
    bus.ren  = rd;
    bus.addr = a[15:0];
    h1 = in_region(a, R1B, R1S);
    h2 = in_region(a, R2B, R2S) && !h1;
    c.wen1 = r && w && h1;
    c.wen2 = r && w && h2;
    c.tag  = tag;
    comb_q.push_back(c);
    if (!r)             q.sel = 0;
    else if (rd && h1)  q.sel = 1;
    else if (rd && h2)  q.sel = 2;
    else                q.sel = 0;
    q.fault = r && (w || rd) && !h1 && !h2;
    q.tag   = tag;
    reg_q.push_back(q);
  endtask

  // Monitor: combinational enables mid-cycle, registered outputs just after the edge.
  initial begin : monitor
    comb_t c;
    reg_t  q;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("wen1", c.tag, int'(bus.wen1), int'(c.wen1));
        chk("wen2", c.tag, int'(bus.wen2), int'(c.wen2));
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        q = reg_q.pop_front();
        chk("out_sel", q.tag, int'(bus.out_sel), q.sel);
        chk("fault", q.tag, int'(bus.fault), int'(q.fault));
      end
    end
  end

  int bnd[10] = '{'h0000, 'h0001, 'h1FFE, 'h1FFF, 'h2000, 'h2001, 'h2FFE, 'h2FFF, 'h3000,
                  'hFFFF};

  initial begin : stim
    int a;
    bus.wen  = 1'b0;
    bus.ren  = 1'b0;
    bus.addr = '0;

    // Reset with requests pending, then release.
    drive(0, 1, 1, 'h0000, "reset0");
    drive(0, 1, 1, 'h0000, "reset1");
    drive(1, 1, 1, 'h0000, "release");
    // Region 1.
    drive(1, 1, 0, 'h0000, "r1_wr_lo");
    drive(1, 1, 0, 'h1FFF, "r1_wr_hi");
    drive(1, 0, 1, 'h1FFF, "r1_rd_hi");
    // Region 2.
    drive(1, 1, 0, 'h2001, "r2_wr");
    drive(1, 0, 1, 'h2000, "r2_rd_lo");
    drive(1, 0, 1, 'h2FFF, "r2_rd_hi");
    // Unmapped.
    drive(1, 1, 1, 'h3000, "unmap_lo");
    drive(1, 1, 1, 'hFFFF, "unmap_hi");
    drive(1, 0, 0, 'h0000, "unmap_idle");
    // Back-to-back reads.
    drive(1, 0, 1, 'h0004, "pipe_r1");
    drive(1, 0, 1, 'h2004, "pipe_r2");
    drive(1, 0, 1, 'h3004, "pipe_un");
    drive(1, 0, 0, 'h0000, "pipe_idle");
    // Idle sweep across boundaries.
    drive(1, 0, 0, 'h0000, "idle_0000");
    drive(1, 0, 0, 'h1FFF, "idle_1fff");
    drive(1, 0, 0, 'h2000, "idle_2000");
    drive(1, 0, 0, 'h3000, "idle_3000");
    // Reset in the cycle after a read.
    drive(1, 0, 1, 'h2000, "midrd_rd");
    drive(0, 0, 0, 'h0000, "midrd_rst");
    drive(1, 0, 0, 'h0000, "midrd_idle");

    // Randomized traffic biased toward region edges, with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) a = bnd[$urandom_range(0, 9)];
      else                           a = int'($urandom_range(0, 'hFFFF));
      drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), a, "rand");
    end

    drive(1, 0, 0, 'h0000, "tail0");
    drive(1, 0, 0, 'h0000, "tail1");
    repeat (4) @(posedge clk);
    #2;
    chk("drain", "scoreboard", comb_q.size() + reg_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
